// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and constants for the instruction fetch controller
//   fetch_entry_t : one buffered fetch result {pc, instr}
//   fetch_state_e : fetch sequencer states
//   align_pc      : clears the byte-offset bits of a redirect target
package fetch_ctrl_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_REQ,
    FS_WAIT
  } fetch_state_e;

  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return {pc[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction-memory and decode handshake bundle for fetch_ctrl
//   imem_* : req/gnt request channel plus in-order rvalid/rdata response channel
//   if_*   : fetch buffer head towards decode, valid/ready
//   master : fetch controller side; slave : memory + decode side
interface fetch_ctrl_if;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [63:0] if_pc_o;
  logic        if_ready_i;

  modport master (
    output imem_req_o, imem_addr_o, if_valid_o, if_instr_o, if_pc_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, if_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, if_valid_o, if_instr_o, if_pc_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, if_ready_i
  );
endinterface

// File: rtl/fetch_ctrl_fifo.sv
// rtl/fetch_ctrl_fifo.sv - fetch buffer of fetch_entry_t with push/pop/flush
//   clk, rst_n          : clock, synchronous active-low reset
//   push, push_data     : write one entry at the tail
//   pop                 : retire the head (ignored when empty)
//   flush               : empty the buffer; overrides push and pop that cycle
//   head                : combinational head entry (meaningless when empty)
//   full, empty, count  : occupancy status
module fetch_fifo
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally at their width.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer: PC, imem request, fetch buffer, redirects
//   clk, rst_n                        : clock, synchronous active-low reset
//   branch_taken_i, branch_target_i   : decode redirect
//   trap_valid_i, trap_pc_i           : trap redirect, wins over branch
//   bus (fetch_ctrl_if.master)        : imem req/gnt/rvalid channel and decode valid/ready head
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          branch_taken_i,
  input  logic [63:0]   branch_target_i,
  input  logic          trap_valid_i,
  input  logic [63:0]   trap_pc_i,
  fetch_ctrl_if.master  bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic          discard_q, discard_d;
  logic          redirect;
  logic [63:0]   target;
  logic          req;
  logic          push;
  logic          pop;
  fetch_entry_t  push_data;
  fetch_entry_t  head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  assign redirect = trap_valid_i || branch_taken_i;
  assign target   = align_pc(trap_valid_i ? trap_pc_i : branch_target_i);

  // pc_q already advanced at grant, so the outstanding request sits one word behind it.
  assign push_data = '{pc: pc_q - 64'(INSTR_BYTES), instr: bus.imem_rdata_i};
  assign pop       = !fifo_empty && bus.if_ready_i;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    req       = 1'b0;
    push      = 1'b0;
    if (redirect) pc_d = target;
    case (state_q)
      FS_IDLE: state_d = FS_REQ;
      FS_REQ: begin
        // Nothing is outstanding here, so free space is simply occupancy < depth.
        req = (fifo_count < CW'(FIFO_DEPTH));
        if (req && bus.imem_gnt_i) begin
          state_d = FS_WAIT;
          // A grant that coincides with a redirect fetched the old path; drop its data.
          if (redirect) discard_d = 1'b1;
          else          pc_d      = pc_q + 64'(INSTR_BYTES);
        end
      end
      FS_WAIT: begin
        if (bus.imem_rvalid_i) begin
          push      = !discard_q && !redirect;
          discard_d = 1'b0;
          state_d   = FS_REQ;
        end else if (redirect) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FS_IDLE;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

  // The in-flight slot is reserved before requesting, so a push can never find the buffer full.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && fifo_full));
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = pc_q;
  assign bus.if_valid_o  = !fifo_empty;
  assign bus.if_instr_o  = head.instr;
  assign bus.if_pc_o     = head.pc;

endmodule
